mult_share_arb: RTL and testbench

MULT_SHARE_ARB -- requirements
Module: mult_share_arb

---
 rtl/mult_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 72 +++++++
 rtl/mult_share_arb.sv | 171 +++++++++++++++++
 tb/tb_mult_share_arb.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shared-multiplier arbiter.
//   OPW   : operand width of the shared multiplier
//   PRW   : full unsigned product width
//   IDW   : requester index width carried with each operation
//   tag_t : per-stage tag travelling alongside the multiplier latency
package mult_pkg;

  localparam int unsigned OPW = 65;
  localparam int unsigned PRW = 130;
  localparam int unsigned IDW = 3;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Pointer-based round-robin arbiter.
// The search starts at the index after the last granted one and wraps around.
// The pointer moves only when 'advance' reports that the grant was accepted.
// Build option MULT_ARB_PRIO0_EN: requester 0 has strict priority, and the
// round-robin runs among requesters 1..NREQ-1.
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   req        : request vector
//   advance    : the current grant was taken; the pointer moves to it
//   gnt        : one-hot grant, or zero when nothing is requested
//   gnt_id     : index of the granted requester
//   gnt_any    : some requester is granted
module rr_arbiter
  import mult_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_any
);

  logic [IDW-1:0]  last_q;
  logic [NREQ-1:0] rr_req;

  always_comb begin
    rr_req  = req;
`ifdef MULT_ARB_PRIO0_EN
    rr_req[0] = 1'b0;
`endif
    gnt_any = 1'b0;
    gnt_id  = '0;
    // Offset k = 1 is the first candidate after the last grant.
    for (int unsigned k = 1; k <= NREQ; k++) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!gnt_any && rr_req[j] && (((32'(last_q) + k) % NREQ) == j)) begin
          gnt_any = 1'b1;
          gnt_id  = j[IDW-1:0];
        end
      end
    end
`ifdef MULT_ARB_PRIO0_EN
    if (req[0]) begin
      gnt_any = 1'b1;
      gnt_id  = '0;
    end
`endif
    for (int unsigned j = 0; j < NREQ; j++) begin
      gnt[j] = gnt_any && (gnt_id == j[IDW-1:0]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // Start the pointer at the top so that requester 0 wins first.
      last_q <= IDW'(NREQ - 1);
    end else if (advance) begin
`ifdef MULT_ARB_PRIO0_EN
      // A priority grant to 0 does not disturb the rotation among 1..NREQ-1.
      if (gnt_id != '0) last_q <= gnt_id;
`else
      last_q <= gnt_id;
`endif
    end
  end

endmodule

// File: rtl/mult_share_arb.sv
// NREQ requesters share one external pipelined 65x65 unsigned multiplier.
// Requesters are granted round-robin. A tag pipeline that matches the
// multiplier latency carries the requester id to the product. Products are
// queued in a result FIFO and handed out in issue order. Credit rule: issue
// only while in-flight + buffered < FIFO_DEPTH. This means a retiring
// product always finds room in the FIFO, and rsp_ready never reaches
// req_ready.
// Build option MULT_ARB_PRIO0_EN: requester 0 has strict priority.
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_a, req_b        : flattened operands, requester i at [65i+64:65i]
//   mul_a, mul_b        : operands to the shared multiplier
//   mul_result          : product, valid MULT_LAT cycles after issue
//   rsp_valid/rsp_ready : response handshake
//   rsp_id, rsp_data    : owning requester and 130-bit product
module mult_share_arb
  import mult_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned MULT_LAT   = 3,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*OPW-1:0] req_a,
  input  logic [NREQ*OPW-1:0] req_b,
  output logic [OPW-1:0]      mul_a,
  output logic [OPW-1:0]      mul_b,
  input  logic [PRW-1:0]      mul_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [PRW-1:0]      rsp_data
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OutW = $clog2(MULT_LAT + 1);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("NREQ must be in 2..8");
  end
  if (MULT_LAT < 1 || MULT_LAT > 8) begin : g_bad_lat
    $error("MULT_LAT must be in 1..8");
  end
  if (FIFO_DEPTH < MULT_LAT + 1) begin : g_bad_depth
    $error("FIFO_DEPTH must be >= MULT_LAT+1");
  end

  // Arbitration and issue
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_any;
  logic            credit_ok;
  logic            xfer;
  logic [OutW-1:0] outstanding;
  logic [CntW-1:0] fifo_cnt_q;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (xfer),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  assign credit_ok = (32'(outstanding) + 32'(fifo_cnt_q)) < FIFO_DEPTH;
  // Gating with reset keeps req_ready low for the whole time reset is asserted.
  assign xfer      = gnt_any && credit_ok && !reset;
  assign req_ready = {NREQ{xfer}} & gnt;

  // Operand mux; hold the last issued operands when idle.
  logic [OPW-1:0] sel_a, sel_b;
  logic [OPW-1:0] mul_a_q, mul_b_q;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (gnt_id == j[IDW-1:0]) begin
        sel_a = req_a[j*OPW +: OPW];
        sel_b = req_b[j*OPW +: OPW];
      end
    end
    mul_a = xfer ? sel_a : mul_a_q;
    mul_b = xfer ? sel_b : mul_b_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else begin
      mul_a_q <= mul_a;
      mul_b_q <= mul_b;
    end
  end

  // Tag pipeline aligned with the multiplier latency
  tag_t tag_q [MULT_LAT];
  logic push;
  logic pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 0; s < MULT_LAT; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0].valid <= xfer;
      tag_q[0].id    <= gnt_id;
      for (int unsigned s = 1; s < MULT_LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  // In-flight count is the number of valid tag stages.
  always_comb begin
    outstanding = '0;
    for (int unsigned s = 0; s < MULT_LAT; s++) begin
      outstanding = outstanding + OutW'(tag_q[s].valid);
    end
  end

  assign push = tag_q[MULT_LAT-1].valid;

  // Result FIFO. The credit rule keeps push-when-full from ever happening.
  logic [PRW-1:0]  fifo_data [FIFO_DEPTH];
  logic [IDW-1:0]  fifo_id   [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(FIFO_DEPTH - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign pop = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr_q] <= mul_result;
      fifo_id[wr_ptr_q]   <= tag_q[MULT_LAT-1].id;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CntW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CntW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Head is forced to zero when empty so that idle outputs are defined.
  assign rsp_valid = (fifo_cnt_q != '0);
  assign rsp_id    = rsp_valid ? fifo_id[rd_ptr_q]   : '0;
  assign rsp_data  = rsp_valid ? fifo_data[rd_ptr_q] : '0;

endmodule

// File: tb/tb_mult_share_arb.sv
module tb_mult_share_arb;
  import mult_pkg::*;

  localparam int unsigned NREQ       = 4;
  localparam int unsigned MULT_LAT   = 3;
  localparam int unsigned FIFO_DEPTH = 8;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*OPW-1:0] req_a = '0;
  logic [NREQ*OPW-1:0] req_b = '0;
  logic [OPW-1:0]      mul_a, mul_b;
  logic [PRW-1:0]      mul_result;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [IDW-1:0]      rsp_id;
  logic [PRW-1:0]      rsp_data;

  int n_tests = 0;
  int n_fail  = 0;

  mult_share_arb #(
    .NREQ       (NREQ),
    .MULT_LAT   (MULT_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [PRW-1:0] prod(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    return {{OPW{1'b0}}, a} * {{OPW{1'b0}}, b};
  endfunction

  // External multiplier: fixed MULT_LAT-cycle pipeline
  logic [PRW-1:0] mpipe [MULT_LAT];
  always @(posedge clk) begin
    mpipe[0] <= prod(mul_a, mul_b);
    for (int s = 1; s < int'(MULT_LAT); s++) mpipe[s] <= mpipe[s-1];
  end
  assign mul_result = mpipe[MULT_LAT-1];

  // Reference model: each issued operation is queued with its product and
  // the cycle it was issued in.
  typedef struct packed {
    logic [IDW-1:0] id;
    logic [PRW-1:0] data;
    int unsigned    t;
  } exp_t;

  exp_t        m_q[$];
  int          m_last = int'(NREQ) - 1;
  int unsigned m_cycle = 0;

  initial forever begin
    exp_t e;
    @(posedge clk);
    if (reset) begin
      m_q.delete();
      m_last  = int'(NREQ) - 1;
      m_cycle = 0;
    end else begin
      if (rsp_valid && rsp_ready && m_q.size() > 0) void'(m_q.pop_front());
      for (int i = 0; i < int'(NREQ); i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id   = IDW'(i);
          e.data = prod(req_a[i*OPW +: OPW], req_b[i*OPW +: OPW]);
          e.t    = m_cycle;
          m_q.push_back(e);
`ifdef MULT_ARB_PRIO0_EN
          if (i != 0) m_last = i;
`else
          m_last = i;
`endif
        end
      end
      m_cycle++;
    end
  end

  function automatic int exp_grant();
`ifdef MULT_ARB_PRIO0_EN
    if (req_valid[0]) return 0;
`endif
    for (int k = 1; k <= int'(NREQ); k++) begin
      int idx;
      idx = (m_last + k) % int'(NREQ);
`ifdef MULT_ARB_PRIO0_EN
      if (idx == 0) continue;
`endif
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    int g;
    g = exp_grant();
    if (reset || g < 0 || m_q.size() >= int'(FIFO_DEPTH)) return '0;
    return NREQ'(1) << g;
  endfunction

  function automatic logic exp_rsp_valid();
    return (m_q.size() > 0) && (m_cycle >= m_q[0].t + MULT_LAT + 1);
  endfunction

  task automatic set_op(input int i, input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    req_a[i*OPW +: OPW] = a;
    req_b[i*OPW +: OPW] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < int'(NREQ); i++) begin
      set_op(i, {1'($urandom), $urandom, $urandom}, {1'($urandom), $urandom, $urandom});
    end
  endtask

  // Leaves the bench at posedge+1 with reset released and inputs idle.
  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = '1;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %0h want 0", req_ready); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
    n_tests++; if (rsp_id !== '0) begin n_fail++; $display("FAIL reset_rsp_id: got %0h want 0", rsp_id); end
    n_tests++; if (rsp_data !== '0) begin n_fail++; $display("FAIL reset_rsp_data: got %0h want 0", rsp_data); end
    n_tests++; if (mul_a !== '0 || mul_b !== '0) begin n_fail++; $display("FAIL reset_mul: got %0h/%0h want 0/0", mul_a, mul_b); end
    @(posedge clk);
    #1 reset = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single();
    int lat;
    do_reset();
    set_op(0, OPW'(3), OPW'(5));
    req_valid = NREQ'(1);
    rsp_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (req_ready !== NREQ'(1)) begin n_fail++; $display("FAIL single_grant: got %0h want 1", req_ready); end
    n_tests++; if (mul_a !== OPW'(3) || mul_b !== OPW'(5)) begin n_fail++; $display("FAIL single_mul: got %0h/%0h want 3/5", mul_a, mul_b); end
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk);
      if (rsp_valid) lat = k;
    end
    n_tests++; if (lat != int'(MULT_LAT) + 1) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", lat, MULT_LAT + 1); end
    n_tests++; if (rsp_id !== '0 || rsp_data !== PRW'(15)) begin n_fail++; $display("FAIL single_rsp: got id %0d data %0h want 0/f", rsp_id, rsp_data); end
    n_tests++; if (mul_a !== OPW'(3)) begin n_fail++; $display("FAIL single_mul_hold: got %0h want 3", mul_a); end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop: rsp_valid got %0b want 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    exp_t q[$];
    exp_t e;
    do_reset();
    rsp_ready = 1'b1;
    for (int c = 0; c < 32; c++) begin
      rand_ops();
      req_valid = (c < 12) ? '1 : '0;
      @(negedge clk);
      if (c < 12) begin
        n_tests++;
        if (req_ready !== (NREQ'(1) << (c % int'(NREQ)))) begin
          n_fail++; $display("FAIL rr_grant[%0d]: got %0h want %0h", c, req_ready, NREQ'(1) << (c % int'(NREQ)));
        end
        e.id   = IDW'(c % int'(NREQ));
        e.data = prod(req_a[(c % int'(NREQ))*OPW +: OPW], req_b[(c % int'(NREQ))*OPW +: OPW]);
        e.t    = 0;
        q.push_back(e);
      end
      if (rsp_valid) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rr_rsp: got unexpected id %0d want none", rsp_id);
        end else begin
          e = q.pop_front();
          if (rsp_id !== e.id || rsp_data !== e.data) begin
            n_fail++; $display("FAIL rr_rsp: got %0d/%0h want %0d/%0h", rsp_id, rsp_data, e.id, e.data);
          end
        end
      end
      @(posedge clk);
      #1;
    end
    n_tests++; if (q.size() != 0) begin n_fail++; $display("FAIL rr_drain: got %0d left want 0", q.size()); end
  endtask

  task automatic test_max_operands();
    int lat;
    do_reset();
    set_op(2, '1, '1);
    req_valid = NREQ'(4);
    rsp_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (req_ready !== NREQ'(4)) begin n_fail++; $display("FAIL max_grant: got %0h want 4", req_ready); end
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk);
      if (rsp_valid) lat = k;
    end
    n_tests++;
    if (lat == 0 || rsp_id !== IDW'(2) || rsp_data !== {{64{1'b1}}, 66'd1}) begin
      n_fail++; $display("FAIL max_rsp: got v%0b id %0d %0h want 2/%0h", rsp_valid, rsp_id, rsp_data, {{64{1'b1}}, 66'd1});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    exp_t q[$];
    exp_t e;
    int xfers, gi;
    do_reset();
    rsp_ready = 1'b0;
    xfers = 0;
    for (int c = 0; c < 30; c++) begin
      rand_ops();
      req_valid = '1;
      @(negedge clk);
      for (int i = 0; i < int'(NREQ); i++) begin
        if (req_valid[i] && req_ready[i]) begin
          xfers++;
          e.id = IDW'(i); e.data = prod(req_a[i*OPW +: OPW], req_b[i*OPW +: OPW]); e.t = 0;
          q.push_back(e);
        end
      end
      @(posedge clk);
      #1;
    end
    n_tests++; if (xfers != int'(FIFO_DEPTH)) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", xfers, FIFO_DEPTH); end
    @(negedge clk);
    n_tests++; if (req_ready !== '0 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_full: got ready %0h valid %0b want 0/1", req_ready, rsp_valid); end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    e = q.pop_front();
    n_tests++; if (rsp_id !== e.id || rsp_data !== e.data) begin n_fail++; $display("FAIL bp_head: got %0d/%0h want %0d/%0h", rsp_id, rsp_data, e.id, e.data); end
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    xfers = 0;
    gi = -1;
    for (int c = 0; c < 10; c++) begin
      rand_ops();
      @(negedge clk);
      for (int i = 0; i < int'(NREQ); i++) begin
        if (req_valid[i] && req_ready[i]) begin
          xfers++; gi = i;
          e.id = IDW'(i); e.data = prod(req_a[i*OPW +: OPW], req_b[i*OPW +: OPW]); e.t = 0;
          q.push_back(e);
        end
      end
      @(posedge clk);
      #1;
    end
    n_tests++; if (xfers != 1) begin n_fail++; $display("FAIL bp_one_pop_one_grant: got %0d want 1", xfers); end
    n_tests++; if (gi != int'(FIFO_DEPTH % NREQ)) begin n_fail++; $display("FAIL bp_regrant_id: got %0d want %0d", gi, FIFO_DEPTH % NREQ); end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL bp_drain: got extra id %0d want none", rsp_id);
        end else begin
          e = q.pop_front();
          if (rsp_id !== e.id || rsp_data !== e.data) begin
            n_fail++; $display("FAIL bp_drain: got %0d/%0h want %0d/%0h", rsp_id, rsp_data, e.id, e.data);
          end
        end
      end
      @(posedge clk);
      #1;
    end
    n_tests++; if (q.size() != 0) begin n_fail++; $display("FAIL bp_left: got %0d want 0", q.size()); end
  endtask

  task automatic test_reset_midflight();
    int xfers;
    bit seen;
    logic [NREQ-1:0] v;
    do_reset();
    rsp_ready = 1'b1;
    v = '1;
    v[0] = 1'b0;
    xfers = 0;
    for (int c = 0; c < 3; c++) begin
      rand_ops();
      req_valid = v;
      @(negedge clk);
      if (|(req_valid & req_ready)) xfers++;
      @(posedge clk);
      #1;
    end
    n_tests++; if (xfers != 3) begin n_fail++; $display("FAIL mid_issue: got %0d want 3", xfers); end
    reset = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    n_tests++; if (seen) begin n_fail++; $display("FAIL mid_discard: got rsp_valid 1 want 0"); end
    req_valid = '1;
    @(negedge clk);
    n_tests++; if (req_ready !== NREQ'(1)) begin n_fail++; $display("FAIL mid_first_grant: got %0h want 1", req_ready); end
    @(posedge clk);
    #1 req_valid = '0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_pair();
    logic [NREQ-1:0] want;
    do_reset();
    rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      rand_ops();
      req_valid = NREQ'(5);
      @(negedge clk);
`ifdef MULT_ARB_PRIO0_EN
      want = NREQ'(1);
`else
      want = (c % 2 == 0) ? NREQ'(1) : NREQ'(4);
`endif
      n_tests++; if (req_ready !== want) begin n_fail++; $display("FAIL pair_grant[%0d]: got %0h want %0h", c, req_ready, want); end
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [NREQ-1:0] er;
    logic            ev;
    do_reset();
    for (int c = 0; c < 460; c++) begin
      rand_ops();
      req_valid = (c < 400) ? NREQ'($urandom) : '0;
      rsp_ready = (c < 400) ? ($urandom_range(0, 9) < 6) : 1'b1;
      @(negedge clk);
      er = exp_ready();
      ev = exp_rsp_valid();
      n_tests++; if (req_ready !== er) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %0h want %0h", c, req_ready, er); end
      n_tests++; if (rsp_valid !== ev) begin n_fail++; $display("FAIL rnd_rsp_valid[%0d]: got %0b want %0b", c, rsp_valid, ev); end
      if (rsp_valid && m_q.size() > 0) begin
        n_tests++;
        if (rsp_id !== m_q[0].id || rsp_data !== m_q[0].data) begin
          n_fail++; $display("FAIL rnd_rsp[%0d]: got %0d/%0h want %0d/%0h", c, rsp_id, rsp_data, m_q[0].id, m_q[0].data);
        end
      end
      @(posedge clk);
      #1;
    end
    n_tests++; if (m_q.size() != 0) begin n_fail++; $display("FAIL rnd_drain: got %0d left want 0", m_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_max_operands();
    test_backpressure();
    test_reset_midflight();
    test_pair();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
